// File: rtl/t3maps_uart_top.sv
// t3maps_uart_top: UART command bridge that buffers payload bytes, shifts them into the T3MAPS chip
// and returns the captured serial readback to the host on request.
module t3maps_uart_top #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int BAUD    = 9600,
   parameter int CLK_DIV = 50,
   parameter int DEPTH   = 64
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       uartRx_pin,
   input  logic       data_in,
   output logic [7:0] cmd,
   output logic [7:0] LED,
   output logic       uartTx_pin,
   output logic       clk_out
);
   localparam int CPB = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CW  = $clog2(CPB + 1);
   localparam int DW  = $clog2(2 * CLK_DIV + 1);
   localparam int AW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int NW  = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, TX} state_t;
   state_t state, nxt;

   logic          rx_s1, rx_s2, rx_prev, rx_busy, rx_valid;
   logic [CW-1:0] rx_cnt;
   logic [3:0]    rx_bit;
   logic [7:0]    rx_sh;

   logic [7:0]    fifo_mem [DEPTH];
   logic [7:0]    rb_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] fifo_cnt, rb_cnt;

   logic [7:0]    w_sh;
   logic [6:0]    w_cap;
   logic [2:0]    w_bits;
   logic [DW-1:0] w_div;
   logic          w_strobe;

   logic [9:0]    tx_frame;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [NW-1:0] tx_idx, tx_nidx;

   logic push, tick, rb_we, w_done, tx_done, go_w, go_t, shifting;

   function automatic logic [AW-1:0] nx(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   // Start bit is re-checked half a bit after the edge, then every bit is sampled at its centre.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_busy  <= 1'b0;
         rx_valid <= 1'b0;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         LED      <= '0;
      end else begin
         rx_s1    <= uartRx_pin;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_valid <= 1'b0;
         if (!rx_busy) begin
            if (rx_prev && !rx_s2) begin
               rx_busy <= 1'b1;
               rx_cnt  <= CW'(CPB / 2 - 1);
               rx_bit  <= '0;
            end
         end else if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
         else begin
            rx_cnt <= CW'(CPB - 1);
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 4'd0) begin
               if (rx_s2) rx_busy <= 1'b0;
            end else if (rx_bit == 4'd9) begin
               rx_busy <= 1'b0;
               if (rx_s2) begin
                  rx_valid <= 1'b1;
                  LED      <= rx_sh;
               end
            end else rx_sh <= {rx_s2, rx_sh[7:1]};
         end
      end
   end

   always_comb begin
      nxt      = state;
      shifting = state == WRITE && !w_strobe;
      tick     = shifting && w_div == DW'(CLK_DIV - 1);
      rb_we    = tick && !clk_out && w_bits == 3'd0;
      w_done   = state == WRITE && w_strobe && w_div == '0;
      tx_nidx  = tx_idx + 1'b1;
      tx_done  = state == TX && tx_bit == 4'd9 && tx_cnt == CW'(CPB - 1) && tx_nidx == rb_cnt;
      push     = state == LOAD && rx_valid && rx_sh != 8'hFE && fifo_cnt != NW'(DEPTH);
      case (state)
         IDLE:    if (rx_valid) nxt = rx_sh == 8'hFF ? LOAD :
                                      (rx_sh == 8'h7F && fifo_cnt != '0) ? WRITE :
                                      (rx_sh == 8'h7E && rb_cnt != '0) ? TX : IDLE;
         LOAD:    if (rx_valid && rx_sh == 8'hFE) nxt = IDLE;
         WRITE:   if (w_done) nxt = IDLE;
         TX:      if (tx_done) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      go_w = state == IDLE && nxt == WRITE;
      go_t = state == IDLE && nxt == TX;
      cmd  = {1'b0, shifting & w_sh[7], shifting, state == WRITE && w_strobe, 4'b0000};
   end

   always_ff @(posedge CLK) state <= !Reset ? IDLE : nxt;

   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr] <= rx_sh;
      if (rb_we) rb_mem[rb_cnt[AW-1:0]] <= {w_cap, data_in};
   end

   // Shift engine: SDI moves on clk_out falls, data_in is captured on the cycle that raises clk_out.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         rb_cnt   <= '0;
         w_sh     <= '0;
         w_cap    <= '0;
         w_bits   <= '0;
         w_div    <= '0;
         w_strobe <= 1'b0;
         clk_out  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr   <= nx(wr_ptr);
            fifo_cnt <= fifo_cnt + 1'b1;
         end
         if (go_w) begin
            w_sh     <= fifo_mem[rd_ptr];
            rd_ptr   <= nx(rd_ptr);
            fifo_cnt <= fifo_cnt - 1'b1;
            w_bits   <= 3'd7;
            w_div    <= '0;
            w_strobe <= 1'b0;
            clk_out  <= 1'b0;
            rb_cnt   <= '0;
         end else if (state == WRITE) begin
            if (w_strobe) w_div <= w_div - 1'b1;
            else if (!tick) w_div <= w_div + 1'b1;
            else begin
               w_div   <= '0;
               clk_out <= !clk_out;
               if (!clk_out) begin
                  w_cap <= {w_cap[5:0], data_in};
                  if (w_bits == 3'd0) rb_cnt <= rb_cnt + 1'b1;
               end else if (w_bits != 3'd0) begin
                  w_sh   <= {w_sh[6:0], 1'b0};
                  w_bits <= w_bits - 1'b1;
               end else if (fifo_cnt != '0) begin
                  w_sh     <= fifo_mem[rd_ptr];
                  rd_ptr   <= nx(rd_ptr);
                  fifo_cnt <= fifo_cnt - 1'b1;
                  w_bits   <= 3'd7;
               end else begin
                  w_strobe <= 1'b1;
                  w_div    <= DW'(2 * CLK_DIV - 1);
               end
            end
         end else begin
            w_strobe <= 1'b0;
            clk_out  <= 1'b0;
         end
      end
   end

   // Frames go out as {stop, data, start} shifted LSB first; the pin lags the frame register by a cycle.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         uartTx_pin <= 1'b1;
         tx_frame   <= '1;
         tx_cnt     <= '0;
         tx_bit     <= '0;
         tx_idx     <= '0;
      end else if (go_t) begin
         tx_frame   <= {1'b1, rb_mem['0], 1'b0};
         tx_cnt     <= '0;
         tx_bit     <= '0;
         tx_idx     <= '0;
         uartTx_pin <= 1'b1;
      end else if (state == TX) begin
         uartTx_pin <= tx_frame[0];
         if (tx_cnt != CW'(CPB - 1)) tx_cnt <= tx_cnt + 1'b1;
         else begin
            tx_cnt <= '0;
            if (tx_bit != 4'd9) begin
               tx_bit   <= tx_bit + 1'b1;
               tx_frame <= {1'b1, tx_frame[9:1]};
            end else begin
               tx_bit   <= '0;
               tx_idx   <= tx_nidx;
               tx_frame <= {1'b1, rb_mem[tx_nidx[AW-1:0]], 1'b0};
            end
         end
      end else uartTx_pin <= 1'b1;
   end
endmodule

// File: tb/tb_t3maps_uart_top.sv
// tb_t3maps_uart_top: randomized scenario bench for the T3MAPS UART bridge with a queue-based
// model of the LOAD/WRITE/TX command protocol and a host-side UART decoder.
module tb_t3maps_uart_top;
   localparam int CLK_HZ  = 1_600_000;
   localparam int BAUD    = 100_000;
   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 16;
   localparam int CPB     = (CLK_HZ + BAUD / 2) / BAUD;

   logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, dmode = 1'b0;
   logic       data_in, uart_tx, clk_out;
   logic [7:0] cmd, led;
   int         compared = 0, mismatched = 0;
   int         pulses = 0, strobes = 0, st_len = 0;
   logic       co_prev = 1'b0, st_prev = 1'b0;
   logic       sdi_q[$];
   logic [7:0] tx_q[$];
   time        tx_t[$];
   logic [7:0] m_fifo[$], m_rb[$];
   bit         m_load = 1'b0;

   t3maps_uart_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
      .CLK(clk), .Reset(rst_n), .uartRx_pin(rx), .data_in(data_in),
      .cmd(cmd), .LED(led), .uartTx_pin(uart_tx), .clk_out(clk_out)
   );

   assign data_in = dmode ? ~cmd[6] : cmd[6];
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (clk_out && !co_prev) begin
         pulses++;
         sdi_q.push_back(cmd[6]);
      end
      co_prev = clk_out;
      if (cmd[4] && !st_prev) begin
         strobes++;
         st_len = 1;
      end else if (cmd[4]) st_len++;
      st_prev = cmd[4];
   end

   always begin : tx_mon
      logic [7:0] b;
      time        t;
      @(negedge uart_tx);
      t = $time;
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (!uart_tx) begin
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1;
            b[i] = uart_tx;
         end
         repeat (CPB) @(posedge clk);
         #1;
         if (uart_tx) begin
            tx_q.push_back(b);
            tx_t.push_back(t);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   function automatic void model_rx(input logic [7:0] b);
      if (m_load) begin
         if (b == 8'hFE) m_load = 1'b0;
         else if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
      end else if (b == 8'hFF) m_load = 1'b1;
   endfunction

   function automatic void model_reset();
      m_fifo.delete();
      m_rb.delete();
      m_load = 1'b0;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (CPB) @(posedge clk);
      end
      rx = 1'b1;
      repeat (3 * CPB) @(posedge clk);
   endtask

   task automatic send_cmd(input logic [7:0] b);
      send_byte(b, 1'b1);
      model_rx(b);
   endtask

   function automatic logic [7:0] rand_payload();
      logic [7:0] b;
      b = 8'($urandom);
      return b == 8'hFE ? 8'h5A : b;
   endfunction

   task automatic do_write(input bit busy);
      int p0, s0, q0, n, budget, errs;
      logic [7:0] mask;
      p0 = pulses; s0 = strobes; q0 = sdi_q.size(); n = m_fifo.size();
      mask = dmode ? 8'hFF : 8'h00;
      send_byte(8'h7F, 1'b1);
      if (busy) begin
         send_byte(8'hFF, 1'b1);
         compared++;
         if (led !== 8'hFF) begin
            mismatched++;
            $display("FAIL busy_led: got %h required ff", led);
         end
      end
      if (n == 0) begin
         repeat (20 * CLK_DIV) @(posedge clk);
         #1;
         compared++;
         if (pulses - p0 !== 0 || cmd !== 8'h00) begin
            mismatched++;
            $display("FAIL empty_write: got %0d pulses cmd %h required 0 pulses cmd 00", pulses - p0, cmd);
         end
         return;
      end
      budget = 4 * (8 * n + 2) * 2 * CLK_DIV;
      while (budget > 0 && !(strobes > s0 && cmd === 8'h00)) begin
         @(posedge clk);
         #1;
         budget--;
      end
      compared++;
      if (budget == 0) begin
         mismatched++;
         $display("FAIL write_timeout: got no completed load strobe, required one");
      end
      compared++;
      if (pulses - p0 !== 8 * n) begin
         mismatched++;
         $display("FAIL clk_pulses: got %0d required %0d", pulses - p0, 8 * n);
      end
      errs = 0;
      for (int i = 0; i < 8 * n; i++) begin
         logic [7:0] b = m_fifo[i / 8];
         if (q0 + i >= sdi_q.size() || sdi_q[q0 + i] !== b[7 - i % 8]) errs++;
      end
      compared++;
      if (errs != 0) begin
         mismatched++;
         $display("FAIL sdi_bits: got %0d wrong bits required 0", errs);
      end
      compared++;
      if (strobes - s0 !== 1 || st_len !== 2 * CLK_DIV) begin
         mismatched++;
         $display("FAIL load_strobe: got %0d pulses of %0d cycles required 1 of %0d", strobes - s0, st_len, 2 * CLK_DIV);
      end
      compared++;
      if (clk_out !== 1'b0) begin
         mismatched++;
         $display("FAIL clk_out_idle: got %b required 0", clk_out);
      end
      m_rb.delete();
      foreach (m_fifo[i]) m_rb.push_back(m_fifo[i] ^ mask);
      m_fifo.delete();
   endtask

   task automatic do_tx();
      int q0, n, budget, errs, gaps;
      q0 = tx_q.size(); n = m_rb.size();
      send_byte(8'h7E, 1'b1);
      budget = (n * 10 + 4) * CPB;
      while (budget > 0 && tx_q.size() - q0 < n) begin
         @(posedge clk);
         #1;
         budget--;
      end
      repeat (2 * CPB) @(posedge clk);
      #1;
      compared++;
      if (tx_q.size() - q0 !== n) begin
         mismatched++;
         $display("FAIL tx_count: got %0d frames required %0d", tx_q.size() - q0, n);
      end
      errs = 0; gaps = 0;
      for (int i = 0; i < n && q0 + i < tx_q.size(); i++) begin
         if (tx_q[q0 + i] !== m_rb[i]) errs++;
         if (i > 0 && tx_t[q0 + i] - tx_t[q0 + i - 1] != 64'(10 * CPB * 10)) gaps++;
      end
      if (n > 0) begin
         compared++;
         if (errs != 0) begin
            mismatched++;
            $display("FAIL tx_bytes: got %0d wrong bytes (first %h) required 0 (first %h)", errs, tx_q[q0], m_rb[0]);
         end
         compared++;
         if (gaps != 0) begin
            mismatched++;
            $display("FAIL tx_spacing: got %0d non back-to-back frames required 0", gaps);
         end
      end
      compared++;
      if (uart_tx !== 1'b1) begin
         mismatched++;
         $display("FAIL tx_idle: got %b required 1", uart_tx);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if (cmd !== 8'h00 || led !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_cmd_led: got cmd %h led %h required 00 00", cmd, led);
      end
      compared++;
      if (uart_tx !== 1'b1 || clk_out !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_tx_clk: got tx %b clk_out %b required 1 0", uart_tx, clk_out);
      end
      rst_n = 1'b1;
      model_reset();
      repeat (4) @(posedge clk);
   endtask

   task automatic test_directed();
      dmode = 1'b0;
      send_cmd(8'hFF); send_cmd(8'h55); send_cmd(8'h01); send_cmd(8'hB1); send_cmd(8'hFE);
      compared++;
      if (led !== 8'hFE) begin
         mismatched++;
         $display("FAIL led_last: got %h required fe", led);
      end
      do_write(1'b0);
      do_tx();
   endtask

   task automatic test_back_to_back();
      do_tx();
   endtask

   task automatic test_errors();
      send_byte(8'hFF, 1'b0);
      compared++;
      if (led !== 8'h7E) begin
         mismatched++;
         $display("FAIL bad_stop: got led %h required 7e", led);
      end
      rx = 1'b0;
      repeat (2) @(posedge clk);
      rx = 1'b1;
      repeat (12 * CPB) @(posedge clk);
      compared++;
      if (led !== 8'h7E) begin
         mismatched++;
         $display("FAIL start_glitch: got led %h required 7e", led);
      end
      send_cmd(8'h11);
      compared++;
      if (led !== 8'h11) begin
         mismatched++;
         $display("FAIL led_update: got %h required 11", led);
      end
      do_write(1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int n;
         logic [7:0] junk;
         n = $urandom_range(1, 8);
         dmode = 1'($urandom_range(0, 1));
         junk = 8'($urandom_range(0, 8'h7D));
         send_cmd(junk);
         send_cmd(8'hFF);
         for (int i = 0; i < n; i++) send_cmd(rand_payload());
         send_cmd(8'hFE);
         do_write(1'b0);
         do_tx();
      end
   endtask

   task automatic test_overflow();
      dmode = 1'b0;
      send_cmd(8'hFF);
      for (int i = 0; i < DEPTH + 5; i++) send_cmd(rand_payload());
      send_cmd(8'hFE);
      do_write(1'b1);
      send_cmd(8'h11);
      send_cmd(8'hFE);
      do_write(1'b0);
      do_tx();
   endtask

   task automatic test_reset_mid_write();
      dmode = 1'b0;
      send_cmd(8'hFF);
      for (int i = 0; i < 4; i++) send_cmd(rand_payload());
      send_cmd(8'hFE);
      send_byte(8'h7F, 1'b1);
      #1;
      compared++;
      if (cmd[5] !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_write: got shift-enable %b required 1", cmd[5]);
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      compared++;
      if (cmd !== 8'h00 || clk_out !== 1'b0 || uart_tx !== 1'b1 || led !== 8'h00) begin
         mismatched++;
         $display("FAIL abort_reset: got cmd %h clk_out %b tx %b led %h required 00 0 1 00", cmd, clk_out, uart_tx, led);
      end
      rst_n = 1'b1;
      model_reset();
      repeat (4) @(posedge clk);
      do_write(1'b0);
      do_tx();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_errors();
      test_random();
      test_overflow();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/t3maps_uart_top.md
# t3maps_uart_top

UART-controlled configuration bridge for the T3MAPS pixel chip. Host bytes arrive at 9600 baud 8N1 and are interpreted as commands or payload. Payload bytes are buffered, shifted serially to the chip on `cmd[6]` with a gated `clk_out`, and the bits returned on `data_in` are captured and sent back over the UART on request. Sits at the FPGA top level between the host serial link and the chip pins.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 9600: UART rate; `CLKS_PER_BIT = CLK_HZ/BAUD` rounded, 10417 by default.
- `CLK_DIV`, 50: system cycles per `clk_out` half-period, so the serial clock runs at 1 MHz.
- `DEPTH`, 64: byte capacity of the payload FIFO and of the readback buffer.
- `CLK`  in  1  system clock, 100 MHz; all logic runs on its rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `uartRx_pin`  in  1  host UART receive line; idles high.
- `data_in`  in  1  serial return from the chip, sampled during WRITE.
- `cmd`  out  8  chip control bus:
  - `[6]` serial data (SDI);
  - `[5]` shift-enable, high during WRITE;
  - `[4]` load strobe;
  - all other bits 0.
- `LED`  out  8  last byte accepted by the UART receiver.
- `uartTx_pin`  out  1  UART transmit to host; idles high.
- `clk_out`  out  1  gated serial clock to the chip.

## Operation
- **UART RX**
  - 2-flop synchronizer on `uartRx_pin`.
  - A falling edge starts a frame; the start bit is re-checked at mid-bit and the frame is aborted if it reads high.
  - 8 data bits are sampled at mid-bit, LSB first.
  - The stop bit must be 1, otherwise the byte is discarded.
  - Each valid byte gives a 1-cycle `rx_valid` and updates `LED`.
- **States:** IDLE, LOAD, WRITE, TX.
- **IDLE**
  - 0xFF enters LOAD.
  - 0x7F enters WRITE, or stays in IDLE if the FIFO is empty.
  - 0x7E enters TX, or stays in IDLE if the readback buffer is empty.
  - Any other byte is ignored.
- **LOAD**
  - 0xFE returns to IDLE and is not stored.
  - Every other byte, including 0xFF and 0x7F, is pushed to the FIFO.
  - When the FIFO is full, further pushes are dropped silently.
- **WRITE**
  - At entry the readback buffer is cleared.
  - FIFO bytes are popped in order and each is shifted MSB first:
    - `cmd[6]` changes on the `clk_out` falling edge;
    - the chip samples SDI on the rising edge;
    - `data_in` is sampled in the system cycle that drives `clk_out` high.
  - Each group of 8 sampled bits, MSB first, forms one byte that is appended to the readback buffer.
  - After the last bit, `clk_out` stays low and `cmd[5]` drops. `cmd[4]` pulses high for 2·`CLK_DIV` cycles.
  - Then the FSM returns to IDLE with the FIFO empty.
- **TX**
  - Readback bytes are sent in order as 8N1 frames, LSB first, at `BAUD`, back to back.
  - The readback buffer is not consumed; TX may be repeated.
  - The FSM returns to IDLE after the final stop bit.
- **Busy handling:** bytes received during WRITE or TX are dropped, but still update `LED`.
- **Reset (`Reset`=0 at a `CLK` edge):**
  - `cmd`=0, `LED`=0, `uartTx_pin`=1, `clk_out`=0;
  - state IDLE, FIFO and readback buffer empty, RX and TX idle.
  - Reset in any state aborts the operation immediately.

## Timing
- Bit time is `CLKS_PER_BIT` cycles, 104.17 µs.
- A received byte is valid about 9.5 bit times after its start edge, i.e. at mid-stop-bit.
- A state change takes effect on the cycle after `rx_valid`.
- WRITE of N bytes:
  - first `clk_out` rise occurs `CLK_DIV` cycles after entry, with SDI already valid;
  - 8N full `clk_out` periods (2·`CLK_DIV` each);
  - then the load strobe;
  - total ≈ (8N+2)·2·`CLK_DIV` cycles.
- TX: the first start bit begins within 2 cycles of entry; each byte takes 10·`CLKS_PER_BIT` cycles.
- `clk_out` is glitch-free, registered, and low whenever not in WRITE.

## Test plan
- Reset pulse low then high with the line idle → `cmd`=0, `LED`=0, `uartTx_pin`=1, `clk_out`=0, state IDLE.
- Send 0xFF, 0x55, 0x01, 0xB1, 0xFE → FIFO holds 3 bytes [0x55, 0x01, 0xB1] and `LED`=0xFE.
- Then send 0x7F with `data_in` looped to `cmd[6]`:
  - 24 `clk_out` pulses;
  - SDI sequence 01010101 00000001 10110001;
  - one `cmd[4]` pulse;
  - readback = [0x55, 0x01, 0xB1].
- Then send 0x7E → `uartTx_pin` emits 3 frames decoding to 0x55, 0x01, 0xB1, then idles high.
- Frame with a stop bit of 0, and a 0x7F sent while the FIFO is empty → byte ignored, no `clk_out` activity, state IDLE.
- Load `DEPTH`+5 bytes, then 0xFE, then 0x7F → exactly 8·`DEPTH` `clk_out` pulses.
- Reset mid-WRITE → outputs return to reset values on the next edge and both buffers are empty.
